// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state encoding and transition function,
// reusable by any TAP model, plus the master's bit-sequencer state codes.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_e;

  // Master sequencer states; DONE is the single TCK-low cycle before the response.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOW  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_RSP  = 3'd4;

  function automatic tap_state_e tap_next(input tap_state_e cur, input logic tms);
    tap_state_e nxt;
    nxt = TEST_LOGIC_RESET;
    case (cur)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Mirror of the target TAP controller, stepped once per TCK rising-edge event.
module jtag_tap_tracker
  import jtag_pkg::*;
(
  input  logic       io_mainClk,
  input  logic       io_asyncResetn,
  input  logic       tck_rise,
  input  logic       tms,
  output logic [3:0] tap_state
);

  tap_state_e state_reg;

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_reg <= TEST_LOGIC_RESET;
    end else if (tck_rise) begin
      state_reg <= tap_next(state_reg, tms);
    end
  end

  assign tap_state = state_reg;

endmodule

// File: rtl/jtag_master.sv
// Command-driven JTAG bit shifter: up to 32 TMS/TDI bits per command, TDO captured
// just before each TCK fall, with a mirrored TAP state for software.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        io_mainClk,
  input  logic        io_asyncResetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_tms,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_tdo,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  input  logic        jtag_tdo,
  output logic [3:0]  tap_state
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  state_reg;
  logic [7:0]  div_cnt_reg;
  logic [4:0]  idx_reg;
  logic [4:0]  len_reg;
  logic [31:0] tms_reg;
  logic [31:0] tdi_reg;
  logic [31:0] tdo_reg;
  logic        tck_reg;
  logic        tms_out_reg;
  logic        tdi_out_reg;
  logic        rsp_valid_reg;
  logic [1:0]  tdo_sync_reg;

  logic        half_done;
  logic        tck_rise;
  logic        last_bit;
  logic [4:0]  idx_next;

  assign half_done = (div_cnt_reg == DIV_LAST);
  assign tck_rise  = (state_reg == ST_LOW) && half_done;
  assign last_bit  = (idx_reg == len_reg);
  assign idx_next  = idx_reg + 5'd1;

  // TDO is asynchronous to io_mainClk; CLK_DIV >= 3 lets it settle before sampling.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      tdo_sync_reg <= 2'b00;
    end else begin
      tdo_sync_reg <= {tdo_sync_reg[0], jtag_tdo};
    end
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_reg     <= ST_IDLE;
      div_cnt_reg   <= '0;
      idx_reg       <= '0;
      len_reg       <= '0;
      tms_reg       <= '0;
      tdi_reg       <= '0;
      tdo_reg       <= '0;
      tck_reg       <= 1'b0;
      tms_out_reg   <= 1'b1;
      tdi_out_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_reg     <= cmd_len;
            tms_reg     <= cmd_tms;
            tdi_reg     <= cmd_tdi;
            idx_reg     <= '0;
            tdo_reg     <= '0;
            div_cnt_reg <= '0;
            tck_reg     <= 1'b0;
            tms_out_reg <= cmd_tms[0];
            tdi_out_reg <= cmd_tdi[0];
            state_reg   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (half_done) begin
            div_cnt_reg <= '0;
            tck_reg     <= 1'b1;
            state_reg   <= ST_HIGH;
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end
        ST_HIGH: begin
          if (half_done) begin
            // Capture on the same edge that drops TCK, i.e. just before the fall.
            div_cnt_reg      <= '0;
            tck_reg          <= 1'b0;
            tdo_reg[idx_reg] <= tdo_sync_reg[1];
            if (last_bit) begin
              state_reg <= ST_DONE;
            end else begin
              idx_reg     <= idx_next;
              tms_out_reg <= tms_reg[idx_next];
              tdi_out_reg <= tdi_reg[idx_next];
              state_reg   <= ST_LOW;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end
        ST_DONE: begin
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_tdo   = tdo_reg;
  assign jtag_tck  = tck_reg;
  assign jtag_tms  = tms_out_reg;
  assign jtag_tdi  = tdi_out_reg;

  jtag_tap_tracker u_tap_tracker (
    .io_mainClk     (io_mainClk),
    .io_asyncResetn (io_asyncResetn),
    .tck_rise       (tck_rise),
    .tms            (tms_out_reg),
    .tap_state      (tap_state)
  );

endmodule

// File: tb/tb_jtag_master.sv
// Randomized scoreboard bench for jtag_master with a behavioural target TDO model.
module tb_jtag_master;
  import jtag_pkg::*;

  localparam int CLK_DIV = 4;
  // 1149.1 graph as tables: next state for TMS=0 and TMS=1.
  localparam int NXT0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  localparam int NXT1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_tms, cmd_tdi, rsp_tdo;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
  logic [3:0]  tap_state;

  typedef struct {
    logic [31:0] tdo;
    int          tap;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int tck_edges = 0;
  int fall_cnt = 0;
  logic tck_prev = 1'b0;
  logic tdi_shadow = 1'b0;
  logic loop_out = 1'b0;
  int mode = 0;            // 0: TDO = TDI one TCK later, 1: TDO = 1, 2: TDO from tdo_word
  logic [31:0] tdo_word = '0;
  int tb_tap = 0;

  jtag_master #(.CLK_DIV(CLK_DIV)) dut (
    .io_mainClk     (clk),
    .io_asyncResetn (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_len        (cmd_len),
    .cmd_tms        (cmd_tms),
    .cmd_tdi        (cmd_tdi),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_tdo        (rsp_tdo),
    .jtag_tck       (jtag_tck),
    .jtag_tms       (jtag_tms),
    .jtag_tdi       (jtag_tdi),
    .jtag_tdo       (jtag_tdo),
    .tap_state      (tap_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign jtag_tdo = (mode == 0) ? loop_out : (mode == 1) ? 1'b1 : tdo_word[fall_cnt[4:0]];

  // Target model: watches TCK at the falling clk edge, updates TDO after each TCK fall.
  always @(negedge clk) begin
    if (!rst_n) begin
      fall_cnt   = 0;
      loop_out   = 1'b0;
      tdi_shadow = 1'b0;
      tck_prev   = 1'b0;
    end else begin
      if (jtag_tck != tck_prev) tck_edges++;
      if (jtag_tck && !tck_prev) tdi_shadow = jtag_tdi;
      if (!jtag_tck && tck_prev) begin
        loop_out = tdi_shadow;
        if (fall_cnt < 31) fall_cnt++;
      end
      tck_prev = jtag_tck;
      if (cmd_valid && cmd_ready) begin
        acc_cyc  = cyc + 1;
        fall_cnt = 0;
        loop_out = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] len_mask(input logic [4:0] len);
    logic [32:0] m;
    m = (33'd1 << (int'(len) + 1)) - 33'd1;
    return m[31:0];
  endfunction

  task automatic monitor();
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=0x%08h required=no_response", rsp_tdo);
        end else begin
          e = sb.pop_front();
          check("rsp_tdo", rsp_tdo, e.tdo);
          check("rsp_tap_state", 32'(tap_state), 32'(e.tap));
          check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          $display("rsp tdo=0x%08h tap=%0d latency=%0d", rsp_tdo, tap_state, cyc - acc_cyc);
        end
      end else if (!rsp_valid) begin
        seen = 1'b0;
      end
    end
  endtask

  task automatic run_cmd(input logic [4:0] len, input logic [31:0] tms, input logic [31:0] tdi,
                         input logic [31:0] exp_tdo, input int rdy_delay, input bit hold);
    exp_t e;
    int   n;
    int   e1;
    for (int i = 0; i <= int'(len); i++) tb_tap = tms[i] ? NXT1[tb_tap] : NXT0[tb_tap];
    e.tdo = exp_tdo;
    e.tap = tb_tap;
    e.lat = 2 * CLK_DIV * (int'(len) + 1) + 1;
    sb.push_back(e);
    cmd_len   = len;
    cmd_tms   = tms;
    cmd_tdi   = tdi;
    rsp_ready = (rdy_delay == 0);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 600) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=no_rsp_valid required=rsp_valid len=%0d", len);
    end
    e1 = tck_edges;
    for (int k = 0; k < rdy_delay; k++) begin
      @(posedge clk); #1;
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_len   = 5'($urandom_range(0, 31));
        cmd_tms   = $urandom;
        cmd_tdi   = $urandom;
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold_rsp_tdo", rsp_tdo, exp_tdo);
        check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
    end
    if (hold) check("hold_tck_edges", 32'(tck_edges - e1), 32'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int          e0;
    int          n;
    logic [4:0]  len;
    logic [31:0] tms, tdi, exp_tdo;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_len = '0;
    cmd_tms = '0;
    cmd_tdi = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_tck", 32'(jtag_tck), 32'd0);
    check("reset_tms", 32'(jtag_tms), 32'd1);
    check("reset_tap_state", 32'(tap_state), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);

    // Five TMS=1 bits then one TMS=0 bit land in Run-Test/Idle.
    mode = 1;
    e0 = tck_edges;
    run_cmd(5'd4, 32'h1F, 32'h0, 32'h1F, 0, 1'b0);
    run_cmd(5'd0, 32'h0, 32'h0, 32'h1, 2, 1'b0);
    check("tap_run_test_idle", 32'(tap_state), 32'd1);
    check("tck_edges_12", 32'(tck_edges - e0), 32'd12);

    // 32-bit loopback shift.
    mode = 0;
    run_cmd(5'd31, 32'h0, 32'hDEADBEEF, 32'hBD5B7DDE, 1, 1'b0);

    // Constant TDO=1 over 8 bits.
    mode = 1;
    run_cmd(5'd7, 32'h0, $urandom, 32'h000000FF, 0, 1'b0);

    // Response held off for 20 cycles while new commands are offered.
    mode = 2;
    tdo_word = $urandom;
    run_cmd(5'd12, 32'h0, $urandom, tdo_word & len_mask(5'd12), 20, 1'b1);

    for (int t = 0; t < 16; t++) begin
      mode     = int'($urandom_range(0, 2));
      tdo_word = $urandom;
      len      = 5'($urandom_range(0, 31));
      tms      = $urandom;
      tdi      = $urandom;
      exp_tdo  = (mode == 0) ? ((tdi << 1) & len_mask(len)) :
                 (mode == 1) ? len_mask(len) : (tdo_word & len_mask(len));
      run_cmd(len, tms, tdi, exp_tdo, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset in the middle of bit 10 of a 32-bit shift: no response may follow.
    mode      = 2;
    tdo_word  = 32'hFFFFFFFF;
    cmd_len   = 5'd31;
    cmd_tms   = $urandom;
    cmd_tdi   = $urandom;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e0 = tck_edges;
    n = 0;
    while ((tck_edges - e0) < 21 && n < 200) begin @(posedge clk); #1; n++; end
    check("reached_bit10", 32'((tck_edges - e0) >= 21), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tck", 32'(jtag_tck), 32'd0);
    check("midreset_tms", 32'(jtag_tms), 32'd1);
    check("midreset_tdi", 32'(jtag_tdi), 32'd0);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_rsp_tdo", rsp_tdo, 32'd0);
    check("midreset_tap_state", 32'(tap_state), 32'd0);
    tb_tap = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("postreset_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (300) @(posedge clk);
    #1;
    check("postreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
